// File: rtl/rrs_alu_pkg.sv
// Shared widths, tag constants and types for the RRS table
// and the integer ALU slots.
package rrs_alu_pkg;

   localparam int WORD_SIZE = 32;
   localparam int UNIT_SIZE = 8;
   localparam int NUM_REGS  = 64;
   localparam int REG_SIZE  = $clog2(NUM_REGS);

   typedef logic [UNIT_SIZE-1:0] tag_t;
   typedef logic [WORD_SIZE-1:0] word_t;
   typedef logic [REG_SIZE-1:0]  reg_idx_t;

   // Tag 0 means the register file already holds the value
   localparam tag_t TAG_NONE = 8'h00;
   localparam tag_t ADD_BASE = 8'h80;
   localparam tag_t MUL_BASE = 8'hA0;
   localparam tag_t LW_BASE  = 8'hC0;

endpackage

// File: rtl/rrs_alu_int_alu.sv
// Combinational signed add/multiply datapath shared
// by the add, mul and address-generation slots.
module int_alu
   import rrs_alu_pkg::*;
(
   input  logic [WORD_SIZE-1:0] a_i,
   input  logic [WORD_SIZE-1:0] b_i,
   output logic [WORD_SIZE-1:0] add_o,
   output logic [WORD_SIZE-1:0] mul_o
);

   // Low word of a two's complement product does not depend on signedness
   assign add_o = a_i + b_i;
   assign mul_o = a_i * b_i;

endmodule

// File: rtl/rrs_alu.sv
// Register Result Status table with CDB snoop clear,
// plus the shared integer ALU instance.
module rrs_alu
   import rrs_alu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_SIZE-1:0]  rrs_addr,
   input  logic                 rrs_we,
   input  logic [UNIT_SIZE-1:0] rrs_wdata,
   output logic [UNIT_SIZE-1:0] rrs_rdata,
   output logic                 rrs_busy,
   input  logic                 cdb_valid,
   input  logic [UNIT_SIZE-1:0] cdb_tag,
   input  logic [WORD_SIZE-1:0] alu_a,
   input  logic [WORD_SIZE-1:0] alu_b,
   output logic [WORD_SIZE-1:0] add_out,
   output logic [WORD_SIZE-1:0] mul_out
);

   tag_t tbl_q [NUM_REGS];
   tag_t tbl_d [NUM_REGS];
   logic clr_en;

   assign clr_en = cdb_valid && (cdb_tag != TAG_NONE);

   // Issue write is applied after the snoop clear so the newest producer wins
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         tbl_d[i] = tbl_q[i];
         if (clr_en && (tbl_q[i] == cdb_tag)) begin
            tbl_d[i] = TAG_NONE;
         end
      end
      if (rrs_we) begin
         tbl_d[rrs_addr] = rrs_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            tbl_q[i] <= TAG_NONE;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            tbl_q[i] <= tbl_d[i];
         end
      end
   end

   assign rrs_rdata = tbl_q[rrs_addr];
   assign rrs_busy  = (rrs_rdata != TAG_NONE);

   int_alu u_int_alu (
      .a_i   (alu_a),
      .b_i   (alu_b),
      .add_o (add_out),
      .mul_o (mul_out)
   );

endmodule

// File: tb/tb_rrs_alu.sv
// Randomized check of rrs_alu against a behavioural table
// and arithmetic model, plus directed corner cases.
module tb_rrs_alu;

   logic        clk;
   logic        rst;
   logic [5:0]  rrs_addr;
   logic        rrs_we;
   logic [7:0]  rrs_wdata;
   logic [7:0]  rrs_rdata;
   logic        rrs_busy;
   logic        cdb_valid;
   logic [7:0]  cdb_tag;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] add_out;
   logic [31:0] mul_out;

   int checks;
   int errors;
   logic [7:0] model [64];
   bit model_ok;

   rrs_alu dut (
      .clk       (clk),
      .rst       (rst),
      .rrs_addr  (rrs_addr),
      .rrs_we    (rrs_we),
      .rrs_wdata (rrs_wdata),
      .rrs_rdata (rrs_rdata),
      .rrs_busy  (rrs_busy),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .add_out   (add_out),
      .mul_out   (mul_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_add(input logic [31:0] a,
                                            input logic [31:0] b);
      longint s;
      s = longint'($signed(a)) + longint'($signed(b));
      return s[31:0];
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] a,
                                            input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      return p[31:0];
   endfunction

   // One clock: drive at negedge, check reads, then apply the table rules
   task automatic step(input logic r, input logic [5:0] a,
                       input logic we, input logic [7:0] wd,
                       input logic cv, input logic [7:0] ct);
      @(negedge clk);
      rst = r; rrs_addr = a; rrs_we = we; rrs_wdata = wd;
      cdb_valid = cv; cdb_tag = ct;
      alu_a = $urandom; alu_b = $urandom;
      #1;
      if (model_ok) begin
         chk("rd", {24'd0, rrs_rdata}, {24'd0, model[a]});
         chk("busy", {31'd0, rrs_busy}, {31'd0, model[a] != 8'd0});
      end
      chk("add", add_out, ref_add(alu_a, alu_b));
      chk("mul", mul_out, ref_mul(alu_a, alu_b));
      @(posedge clk);
      if (r) begin
         foreach (model[i]) model[i] = 8'd0;
         model_ok = 1'b1;
      end else begin
         if (cv && ct != 8'd0)
            foreach (model[i]) if (model[i] == ct) model[i] = 8'd0;
         if (we) model[a] = wd;
      end
   endtask

   task automatic peek(input string tag, input logic [5:0] a,
                       input logic [7:0] exp);
      @(negedge clk);
      rst = 0; rrs_we = 0; cdb_valid = 0; rrs_addr = a;
      #1;
      chk(tag, {24'd0, rrs_rdata}, {24'd0, exp});
      chk({tag, "_busy"}, {31'd0, rrs_busy}, {31'd0, exp != 8'd0});
   endtask

   task automatic alu_vec(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ea, input logic [31:0] em);
      @(negedge clk);
      alu_a = a; alu_b = b;
      #1;
      chk("vec_add", add_out, ea);
      chk("vec_mul", mul_out, em);
   endtask

   function automatic logic [7:0] pick_tag();
      case ($urandom_range(0, 4))
         0: return 8'h00;
         1: return 8'h81;
         2: return 8'hA2;
         3: return 8'hC3;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      checks = 0; errors = 0; model_ok = 0;
      rst = 1; rrs_addr = 0; rrs_we = 0; rrs_wdata = 0;
      cdb_valid = 0; cdb_tag = 0; alu_a = 0; alu_b = 0;

      step(1, 0, 0, 0, 0, 0);
      peek("rst0", 0, 8'h00);
      peek("rst5", 5, 8'h00);
      peek("rst63", 63, 8'h00);

      step(0, 5, 1, 8'hA3, 0, 0);
      peek("wr5", 5, 8'hA3);
      peek("wr6", 6, 8'h00);

      step(0, 3, 1, 8'hC1, 0, 0);
      step(0, 9, 1, 8'hC1, 0, 0);
      step(0, 4, 1, 8'hC2, 0, 0);
      step(0, 0, 0, 0, 1, 8'hC1);
      peek("clr3", 3, 8'h00);
      peek("clr9", 9, 8'h00);
      peek("keep4", 4, 8'hC2);

      step(0, 7, 1, 8'h81, 0, 0);
      step(0, 8, 1, 8'h81, 0, 0);
      step(0, 7, 1, 8'h85, 1, 8'h81);
      peek("coll7", 7, 8'h85);
      peek("coll8", 8, 8'h00);

      step(0, 10, 1, 8'h00, 1, 8'h00);
      step(0, 4, 0, 0, 1, 8'h00);
      peek("tag0", 4, 8'hC2);

      step(0, 2, 1, 8'h55, 0, 0);
      step(1, 2, 1, 8'h90, 1, 8'h55);
      peek("rstwe2", 2, 8'h00);
      peek("rst4", 4, 8'h00);

      alu_vec(32'd7, -32'sd3, 32'd4, 32'hFFFFFFEB);
      alu_vec(32'h7FFFFFFF, 32'd1, 32'h80000000, 32'h7FFFFFFF);
      alu_vec(-32'sd6, 32'd7, 32'h00000001, 32'hFFFFFFD6);
      alu_vec(32'h10000, 32'h10000, 32'h00020000, 32'h00000000);

      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 199) == 0),
              6'($urandom_range(0, 15) == 0 ? $urandom : $urandom_range(0, 11)),
              ($urandom_range(0, 2) != 0),
              pick_tag(),
              ($urandom_range(0, 1) == 1),
              pick_tag());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rrs_alu.md
Name: rrs_alu

Overview:
- Register Result Status (RRS) table for the Tomasulo-style reservation-station front end.
- Records, per architectural register, the 8-bit tag of the functional-unit slot that will produce its next value.
- Contains the shared signed 32-bit ADD and MUL combinational datapaths used by the add, mul and address-generation slots.
- Sits beside the reservation-station array, which writes RRS on issue and snoops the CDB.

Parameters:
- NUM_REGS, 64, number of architectural registers (table depth).
- UNIT_SIZE, 8, width of a unit/slot tag.
- WORD_SIZE, 32, ALU operand/result width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rrs_addr  input  6  register index for read and write.
- rrs_we  input  1  write enable; 1 = write rrs_wdata into entry rrs_addr.
- rrs_wdata  input  8  producer tag to record.
- rrs_rdata  output  8  current tag of entry rrs_addr; 0 = value ready in register file.
- rrs_busy  output  1  (rrs_rdata != 0).
- cdb_valid  input  1  a result is being broadcast this cycle.
- cdb_tag  input  8  tag of the broadcasting slot.
- alu_a  input  32  signed operand A.
- alu_b  input  32  signed operand B.
- add_out  output  32  signed alu_a + alu_b.
- mul_out  output  32  signed alu_a * alu_b.

Behaviour:
- Storage: NUM_REGS x UNIT_SIZE flops. Tag value 0 is reserved to mean "no pending producer".
- Reset: when rst=1 at a rising edge, all entries become 0. rst overrides rrs_we and CDB clear in that cycle. rrs_rdata therefore reads 0 the cycle after reset.
- Read: combinational; rrs_rdata = table[rrs_addr] as of the last edge.
- Read during write: a read of the address being written returns the old value. The new tag is visible from the next cycle; there is no bypass.
- Write: at the rising edge with rrs_we=1 and rst=0, table[rrs_addr] <= rrs_wdata. Writing 0 is legal and marks the register ready.
- CDB clear: at the rising edge with cdb_valid=1, cdb_tag!=0 and rst=0, every entry equal to cdb_tag is set to 0 in the same cycle. Multiple matching entries all clear.
- Simultaneous write and clear:
  - Write targets an entry that also matches cdb_tag: the write wins; the entry takes rrs_wdata (the newest producer must not be lost).
  - Other matching entries still clear.
- cdb_valid with cdb_tag=0 has no effect.
- Out-of-range addresses cannot occur; the 6-bit index covers all 64 entries.
- ADD: purely combinational, zero latency. add_out = low 32 bits of the signed sum; overflow wraps (two's complement) with no flag.
- MUL: purely combinational, zero latency. mul_out = low 32 bits of the signed 64-bit product, which is sign-agnostic. No saturation.
- The ALU outputs are independent of clk/rst.

Decomposition:
- Shared package: WORD_SIZE, UNIT_SIZE, REG_SIZE, NUM_REGS, the TAG_NONE=8'h00 constant, and slot-base tag constants (e.g. ADD_BASE, MUL_BASE, LW_BASE) used by the RS array.
- One natural sub-module: int_alu, holding the combinational add/mul, instantiated once here and reusable by the RS slots. The table logic stays in rrs_alu.

Test Plan:
- Reset: pulse rst, then read addresses 0, 5 and 63 -> rrs_rdata=0x00, rrs_busy=0.
- Write then read: write addr 5 <= 0xA3; same-cycle read of 5 returns 0x00; the next cycle returns 0xA3 with busy=1. Entry 6 stays 0.
- CDB clear:
  - Setup: addr 3 = 0xC1, addr 9 = 0xC1, addr 4 = 0xC2.
  - Stimulus: broadcast cdb_tag=0xC1.
  - Response: next cycle addr 3=0, addr 9=0, addr 4=0xC2.
- Write vs clear collision:
  - Setup: addr 7 = 0x81.
  - Stimulus: in one cycle write addr 7 <= 0x85 and broadcast 0x81.
  - Response: addr 7=0x85.
- Reset mid-operation: rst=1 together with rrs_we=1 (addr 2 <= 0x90) -> addr 2=0 afterwards.
- ALU vectors:
  - 7 + (-3) -> add 4; 0x7FFFFFFF + 1 -> add 0x80000000.
  - -6 * 7 -> mul 0xFFFFFFD6; 0x10000 * 0x10000 -> mul 0x00000000.
